risc_int_ctrl: RTL and testbench

RISC_INT_CTRL -- requirements
Module: risc_int_ctrl

---
 rtl/risc_pkg.sv | 12 +
 rtl/risc_prio_enc.sv | 20 ++
 rtl/risc_int_ctrl.sv | 106 ++++++++++
 tb/tb_risc_int_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC interrupt controller: FSM encoding and vector defaults.
package risc_pkg;
    localparam int RISC_INT_VEC_W = 32;
    localparam logic [RISC_INT_VEC_W-1:0] RISC_VEC_BASE = 32'h0000_0100;
    localparam int RISC_VEC_STRIDE = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;
endpackage

// File: rtl/risc_prio_enc.sv
// Fixed-priority encoder: lowest set bit of req wins; idx is 0 when nothing is set.
module risc_prio_enc #(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0] req,
    output logic           valid,
    output logic [4:0]     idx
);
    always_comb begin
        valid = 1'b0;
        idx   = 5'd0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 5'(i);
            end
        end
    end
endmodule

// File: rtl/risc_int_ctrl.sv
// Edge-triggered, maskable, fixed-priority interrupt controller with IDLE/REQ/SERVICE handshake.
// Optional nested preemption from SERVICE is enabled with macro RISC_INTC_NESTING_EN.
module risc_int_ctrl
    import risc_pkg::*;
#(
    parameter int                         NCH        = 8,
    parameter logic [RISC_INT_VEC_W-1:0]  VEC_BASE   = RISC_VEC_BASE,
    parameter int                         VEC_STRIDE = RISC_VEC_STRIDE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            irq_in,
    input  logic                      mask_we,
    input  logic [NCH-1:0]            mask_wdata,
    input  logic                      int_ack,
    input  logic                      eoi,
    output logic                      INT,
    output logic [RISC_INT_VEC_W-1:0] int_vec,
    output logic [4:0]                int_id,
    output logic [NCH-1:0]            pending
);
    localparam logic [NCH-1:0] ONE = NCH'(1);

    intc_state_t    state, state_n;
    logic [NCH-1:0] prev, mask, isr;
    logic [NCH-1:0] rise, eligible, req_vec, isr_low, win_oh;
    logic           win_vld, ack_take, eoi_take;
    logic [4:0]     win_idx;
    logic [RISC_INT_VEC_W-1:0] vec_calc;

    assign rise     = irq_in & ~prev;
    assign eligible = pending & ~mask;
    assign isr_low  = isr & (~isr + ONE);
    assign win_oh   = ONE << win_idx;
    assign vec_calc = VEC_BASE + RISC_INT_VEC_W'(win_idx) * RISC_INT_VEC_W'(VEC_STRIDE);

`ifdef RISC_INTC_NESTING_EN
    // Only channels strictly above every in-service bit may compete; all ones when isr is empty.
    logic [NCH-1:0] above;
    assign above   = isr_low - ONE;
    assign req_vec = eligible & above;
`else
    assign req_vec = eligible;
`endif

    risc_prio_enc #(.NCH(NCH)) u_prio (
        .req   (req_vec),
        .valid (win_vld),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        ack_take = 1'b0;
        eoi_take = 1'b0;
        case (state)
            IDLE: if (win_vld) state_n = REQ;
            REQ: begin
                if (int_ack) begin
                    ack_take = win_vld;
                    state_n  = (win_vld || (|isr)) ? SERVICE : IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    eoi_take = 1'b1;
                    state_n  = (|(isr & ~isr_low)) ? SERVICE : IDLE;
                end
`ifdef RISC_INTC_NESTING_EN
                else if (win_vld) state_n = REQ;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    assign INT = (state == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            mask    <= '1;
            pending <= '0;
            isr     <= '0;
            int_id  <= '0;
            int_vec <= '0;
        end else begin
            prev <= irq_in;
            if (mask_we) mask <= mask_wdata;
            // A new edge wins over the ack clear of the same channel.
            pending <= (pending & ~(ack_take ? win_oh : '0)) | rise;
            if (ack_take) begin
                int_id  <= win_idx;
                int_vec <= vec_calc;
                isr     <= isr | win_oh;
            end else if (eoi_take) begin
                isr <= isr & ~isr_low;
            end
        end
    end
endmodule

// File: tb/tb_risc_int_ctrl.sv
// Self-checking bench for risc_int_ctrl: directed vector table, corner sequences, random run vs model.
module tb_risc_int_ctrl;
    localparam int NCH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  irq_in, mask_wdata, pending;
    logic            mask_we, int_ack, eoi, INT;
    logic [31:0]     int_vec;
    logic [4:0]      int_id;

    int pass_n = 0;
    int tot_n  = 0;

    always #5 clk = ~clk;

    risc_int_ctrl #(.NCH(NCH)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_ack(int_ack), .eoi(eoi), .INT(INT), .int_vec(int_vec), .int_id(int_id),
        .pending(pending)
    );

    typedef struct {
        logic [7:0]  irq;
        logic        mwe;
        logic [7:0]  mwd;
        logic        ack;
        logic        eoi;
        logic        e_int;
        logic [4:0]  e_id;
        logic [31:0] e_vec;
        logic [7:0]  e_pend;
    } vec_t;

    vec_t tbl[20];

    // Reference model state
    bit [7:0]    m_pend, m_mask, m_prev;
    bit          m_int;
    int          m_stack[$];
    logic [4:0]  m_id;
    logic [31:0] m_vec;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_in();
        irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
    endtask

    task automatic wait_int(input int budget, input string nm);
        int n = 0;
        while (!INT && n < budget) begin
            tick();
            n++;
        end
        chk({nm, " int"}, 64'(INT), 64'd1);
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int m_winner();
        int lim = NCH;
        foreach (m_stack[k]) if (m_stack[k] < lim) lim = m_stack[k];
        for (int i = 0; i < lim; i++) if (m_pend[i] && !m_mask[i]) return i;
        return -1;
    endfunction

    // One clock of the controller, described by its rules rather than its encoding.
    task automatic m_step();
        int w = m_winner();
        bit [7:0] clr = '0;
        if (m_int) begin
            if (int_ack) begin
                if (w >= 0) begin
                    m_id  = 5'(w);
                    m_vec = 32'h100 + 32'(w) * 4;
                    m_stack.push_back(w);
                    clr[w] = 1'b1;
                end
                m_int = 1'b0;
            end
        end else if (m_stack.size() > 0) begin
            if (eoi) begin
                int mi = 0;
                foreach (m_stack[k]) if (m_stack[k] < m_stack[mi]) mi = k;
                m_stack.delete(mi);
            end
`ifdef RISC_INTC_NESTING_EN
            else if (w >= 0) m_int = 1'b1;
`endif
        end else if (w >= 0) begin
            m_int = 1'b1;
        end
        m_pend = (m_pend & ~clr) | (irq_in & ~m_prev);
        m_prev = irq_in;
        if (mask_we) m_mask = mask_wdata;
    endtask

    initial begin
        //         irq   mwe mwd    ack eoi  int id  vec          pend
        tbl[0]  = '{8'h00, 1, 8'h00, 0, 0,   0, 0, 32'h000, 8'h00};
        tbl[1]  = '{8'h08, 0, 8'h00, 0, 0,   0, 0, 32'h000, 8'h08};
        tbl[2]  = '{8'h00, 0, 8'h00, 0, 0,   1, 0, 32'h000, 8'h08};
        tbl[3]  = '{8'h00, 0, 8'h00, 1, 0,   0, 3, 32'h10C, 8'h00};
        tbl[4]  = '{8'h00, 0, 8'h00, 0, 1,   0, 3, 32'h10C, 8'h00};
        tbl[5]  = '{8'h22, 0, 8'h00, 0, 0,   0, 3, 32'h10C, 8'h22};
        tbl[6]  = '{8'h00, 0, 8'h00, 0, 0,   1, 3, 32'h10C, 8'h22};
        tbl[7]  = '{8'h00, 0, 8'h00, 1, 0,   0, 1, 32'h104, 8'h20};
        tbl[8]  = '{8'h00, 0, 8'h00, 0, 0,   0, 1, 32'h104, 8'h20};
        tbl[9]  = '{8'h00, 0, 8'h00, 0, 1,   0, 1, 32'h104, 8'h20};
        tbl[10] = '{8'h00, 0, 8'h00, 0, 0,   1, 1, 32'h104, 8'h20};
        tbl[11] = '{8'h00, 0, 8'h00, 1, 0,   0, 5, 32'h114, 8'h00};
        tbl[12] = '{8'h00, 0, 8'h00, 0, 1,   0, 5, 32'h114, 8'h00};
        tbl[13] = '{8'h04, 1, 8'hFF, 0, 0,   0, 5, 32'h114, 8'h04};
        tbl[14] = '{8'h00, 0, 8'h00, 0, 0,   0, 5, 32'h114, 8'h04};
        tbl[15] = '{8'h00, 0, 8'h00, 0, 0,   0, 5, 32'h114, 8'h04};
        tbl[16] = '{8'h00, 1, 8'hFB, 0, 0,   0, 5, 32'h114, 8'h04};
        tbl[17] = '{8'h00, 0, 8'h00, 0, 0,   1, 5, 32'h114, 8'h04};
        tbl[18] = '{8'h00, 0, 8'h00, 1, 0,   0, 2, 32'h108, 8'h00};
        tbl[19] = '{8'h00, 1, 8'h00, 0, 1,   0, 2, 32'h108, 8'h00};

        clr_in();
        rst = 1'b1;
        #1;
        chk("rst int", 64'(INT), 64'd0);
        chk("rst pend", 64'(pending), 64'd0);
        chk("rst id", 64'(int_id), 64'd0);
        chk("rst vec", 64'(int_vec), 64'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            irq_in = tbl[i].irq; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd;
            int_ack = tbl[i].ack; eoi = tbl[i].eoi;
            tick();
            chk($sformatf("row%0d int", i), 64'(INT), 64'(tbl[i].e_int));
            chk($sformatf("row%0d id", i), 64'(int_id), 64'(tbl[i].e_id));
            chk($sformatf("row%0d vec", i), 64'(int_vec), 64'(tbl[i].e_vec));
            chk($sformatf("row%0d pend", i), 64'(pending), 64'(tbl[i].e_pend));
        end
        clr_in();

        // Channel 0 arriving while channel 4 is in service
        irq_in = 8'h10; tick(); irq_in = 8'h00;
        wait_int(4, "n4");
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("n4 id", 64'(int_id), 64'd4);
        chk("n4 int low", 64'(INT), 64'd0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("stray ack id", 64'(int_id), 64'd4);
        irq_in = 8'h01; tick(); irq_in = 8'h00;
        tick();
`ifdef RISC_INTC_NESTING_EN
        chk("nest int", 64'(INT), 64'd1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("nest id", 64'(int_id), 64'd0);
        chk("nest vec", 64'(int_vec), 64'h100);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("nest eoi1 int", 64'(INT), 64'd0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick(); tick();
        chk("nest idle int", 64'(INT), 64'd0);
        chk("nest idle pend", 64'(pending), 64'd0);
`else
        chk("flat int0", 64'(INT), 64'd0);
        tick();
        chk("flat int1", 64'(INT), 64'd0);
        chk("flat pend", 64'(pending), 64'h01);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("flat eoi int", 64'(INT), 64'd0);
        tick();
        chk("flat req", 64'(INT), 64'd1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("flat id", 64'(int_id), 64'd0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk("flat idle int", 64'(INT), 64'd0);
`endif

        // Edge on channel 6 during its own ack cycle
        irq_in = 8'h40; tick(); irq_in = 8'h00;
        wait_int(4, "c6");
        int_ack = 1'b1; irq_in = 8'h40; tick(); int_ack = 1'b0; irq_in = 8'h00;
        chk("c6 id", 64'(int_id), 64'd6);
        chk("c6 pend kept", 64'(pending), 64'h40);
        chk("c6 int low", 64'(INT), 64'd0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        wait_int(4, "c6 again");
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("c6 id2", 64'(int_id), 64'd6);
        chk("c6 pend2", 64'(pending), 64'h00);
        eoi = 1'b1; tick(); eoi = 1'b0;

        // Asynchronous reset while requesting
        irq_in = 8'h08; tick(); irq_in = 8'h00;
        wait_int(4, "rq");
        #2 rst = 1'b1;
        #1;
        chk("arst int", 64'(INT), 64'd0);
        chk("arst pend", 64'(pending), 64'd0);
        chk("arst id", 64'(int_id), 64'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
        tick(); tick(); tick();
        chk("post rst int", 64'(INT), 64'd0);
        irq_in = 8'h08; tick(); irq_in = 8'h00;
        wait_int(4, "post rst edge");
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("post rst id", 64'(int_id), 64'd3);

        // Randomized run against the reference model
        do_reset();
        m_pend = '0; m_mask = '1; m_prev = '0; m_int = 1'b0; m_stack.delete();
        m_id = '0; m_vec = '0;
        for (int c = 0; c < 3000; c++) begin
            irq_in     = 8'($urandom) & 8'($urandom);
            mask_we    = ($urandom_range(15) == 0);
            mask_wdata = 8'($urandom) & 8'($urandom) & 8'($urandom);
            int_ack    = ($urandom_range(2) == 0);
            eoi        = ($urandom_range(3) == 0);
            @(posedge clk);
            m_step();
            @(negedge clk);
            chk($sformatf("rand c%0d", c), {18'd0, INT, int_id, int_vec, pending},
                {18'd0, m_int, m_id, m_vec, m_pend});
        end

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
